// File: rtl/vga_timing_gen.sv
// VGA 640x480 timing generator: pixel-rate divider, h/v counters and
// registered active/h_sync/v_sync decodes aligned with x and y.
//
// Ports:
//   clk         system clock
//   rst         asynchronous active-high reset
//   pix_tick    one-clk strobe per pixel period (every DIV clks)
//   h_sync      horizontal sync, active low
//   v_sync      vertical sync, active low
//   active      current pixel lies in the visible area
//   x, y        current pixel column / line
//   frame_start one-clk strobe on the first pixel of each frame
module vga_timing_gen #(
    parameter int DIV      = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk,
    input  logic       rst,
    output logic       pix_tick,
    output logic       h_sync,
    output logic       v_sync,
    output logic       active,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [3:0] DIV_LAST = 4'(DIV - 1);

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
    localparam logic [9:0] H_SS   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SE   = 10'(H_ACTIVE + H_FP + H_SYNC);

    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
    localparam logic [9:0] V_SS   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SE   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [3:0] div;
    logic [9:0] h;
    logic [9:0] v;
    logic [9:0] h_nxt;
    logic [9:0] v_nxt;

    assign pix_tick = (div == DIV_LAST);

    always_comb begin
        h_nxt = h;
        v_nxt = v;
        if (pix_tick) begin
            if (h == H_LAST) begin
                h_nxt = '0;
                v_nxt = (v == V_LAST) ? '0 : v + 10'd1;
            end else begin
                h_nxt = h + 10'd1;
            end
        end
    end

    // Decodes are taken from the next counter values so that they
    // update on the same edge as x/y instead of one pixel late.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div    <= '0;
            h      <= '0;
            v      <= '0;
            active <= 1'b1;
            h_sync <= 1'b1;
            v_sync <= 1'b1;
        end else begin
            div    <= pix_tick ? 4'd0 : div + 4'd1;
            h      <= h_nxt;
            v      <= v_nxt;
            active <= (h_nxt < H_VIS) && (v_nxt < V_VIS);
            h_sync <= !((h_nxt >= H_SS) && (h_nxt < H_SE));
            v_sync <= !((v_nxt >= V_SS) && (v_nxt < V_SE));
        end
    end

    assign x           = h;
    assign y           = v;
    assign frame_start = pix_tick && (h == 10'd0) && (v == 10'd0);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed testbench for vga_timing_gen: default timing at DIV=4 and DIV=2,
// plus a shrunken-parameter instance for whole-frame and wrap corner cases.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DIV=4, default VGA timing
    logic       rst4;
    logic       t4, hs4, vs4, a4, fs4;
    logic [9:0] x4, y4;

    // DIV=2, default VGA timing
    logic       rst2;
    logic       t2, hs2, vs2, a2, fs2;
    logic [9:0] x2, y2;

    // DIV=3, small frame: line 8+2+3+2=15, frame 6+2+2+2=12
    logic       rsts;
    logic       ts, hss, vss, as_, fss;
    logic [9:0] xs, ys;

    vga_timing_gen #(.DIV(4)) u4 (
        .clk(clk), .rst(rst4), .pix_tick(t4), .h_sync(hs4),
        .v_sync(vs4), .active(a4), .x(x4), .y(y4), .frame_start(fs4)
    );

    vga_timing_gen #(.DIV(2)) u2 (
        .clk(clk), .rst(rst2), .pix_tick(t2), .h_sync(hs2),
        .v_sync(vs2), .active(a2), .x(x2), .y(y2), .frame_start(fs2)
    );

    vga_timing_gen #(
        .DIV(3),
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2)
    ) us (
        .clk(clk), .rst(rsts), .pix_tick(ts), .h_sync(hss),
        .v_sync(vss), .active(as_), .x(xs), .y(ys), .frame_start(fss)
    );

    int nvec = 0;
    int nerr = 0;

    typedef struct {
        int          e;
        logic [24:0] exp;
    } vec_t;

    vec_t vt[14];

    function automatic vec_t mk(input int e, input logic t, input logic f,
                                input int xv, input int yv, input logic a,
                                input logic hs, input logic vs);
        vec_t r;
        r.e   = e;
        r.exp = {t, f, 10'(xv), 10'(yv), a, hs, vs};
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h (%0d) want 0x%0h (%0d)",
                     nm, act, act, exp, exp);
        end
    endtask

    // advance n rising edges, ending on the following falling edge
    task automatic adv(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    function automatic logic [24:0] s4();
        return {t4, fs4, x4, y4, a4, hs4, vs4};
    endfunction

    localparam logic [24:0] RST_VEC = {1'b0, 1'b0, 10'd0, 10'd0,
                                       1'b1, 1'b1, 1'b1};

    initial begin
        int cur;
        int bad, acnt, htk, hclk, hstart;
        int f0, f1, vclk, vx, vy;
        logic corner, cok;

        rst4 = 1'b1;
        rst2 = 1'b1;
        rsts = 1'b1;
        @(negedge clk);
        adv(2);
        chk("reset_state", 32'(s4()), 32'(RST_VEC));

        // table-driven first-line checks, e = edges since rst release
        vt[0]  = mk(0,    0, 0, 0,   0, 1, 1, 1);
        vt[1]  = mk(3,    1, 1, 0,   0, 1, 1, 1);
        vt[2]  = mk(4,    0, 0, 1,   0, 1, 1, 1);
        vt[3]  = mk(7,    1, 0, 1,   0, 1, 1, 1);
        vt[4]  = mk(8,    0, 0, 2,   0, 1, 1, 1);
        vt[5]  = mk(2559, 1, 0, 639, 0, 1, 1, 1);
        vt[6]  = mk(2560, 0, 0, 640, 0, 0, 1, 1);
        vt[7]  = mk(2623, 1, 0, 655, 0, 0, 1, 1);
        vt[8]  = mk(2624, 0, 0, 656, 0, 0, 0, 1);
        vt[9]  = mk(3007, 1, 0, 751, 0, 0, 0, 1);
        vt[10] = mk(3008, 0, 0, 752, 0, 0, 1, 1);
        vt[11] = mk(3199, 1, 0, 799, 0, 0, 1, 1);
        vt[12] = mk(3200, 0, 0, 0,   1, 1, 1, 1);
        vt[13] = mk(3203, 1, 0, 0,   1, 1, 1, 1);

        rst4 = 1'b0;
        cur  = 0;
        for (int i = 0; i < 14; i++) begin
            adv(vt[i].e - cur);
            cur = vt[i].e;
            chk($sformatf("vec%0d_e%0d", i, vt[i].e),
                32'(s4()), 32'(vt[i].exp));
        end

        // full line at DIV=4
        rst4 = 1'b1;
        adv(1);
        rst4 = 1'b0;
        bad = 0; acnt = 0; htk = 0; hclk = 0; hstart = -1;
        for (int e = 0; e < 3200; e++) begin
            if (t4) begin
                if (int'(x4) != e / 4 || y4 != 10'd0) bad++;
                if (a4) acnt++;
                if (!hs4) htk++;
            end
            if (!hs4) begin
                hclk++;
                if (hstart < 0) hstart = int'(x4);
            end
            adv(1);
        end
        chk("line_x_seq", 32'(bad), 32'd0);
        chk("line_active_ticks", 32'(acnt), 32'd640);
        chk("line_hsync_ticks", 32'(htk), 32'd96);
        chk("line_hsync_clks", 32'(hclk), 32'd384);
        chk("line_hsync_start_x", 32'(hstart), 32'd656);
        chk("line_wrap_xy", {12'd0, x4, y4}, {12'd0, 10'd0, 10'd1});

        // mid-line async reset at x=700, div=2 (inside h_sync)
        rst4 = 1'b1;
        adv(1);
        rst4 = 1'b0;
        adv(2802);
        chk("pre_rst_x", 32'(x4), 32'd700);
        chk("pre_rst_hsync", 32'(hs4), 32'd0);
        #2 rst4 = 1'b1;
        #1 chk("async_rst_outputs", 32'(s4()), 32'(RST_VEC));
        bad = 0;
        for (int e = 0; e < 6; e++) begin
            @(posedge clk or negedge clk);
            #1;
            if (s4() !== RST_VEC) bad++;
        end
        chk("rst_hold_no_glitch", 32'(bad), 32'd0);
        @(negedge clk);
        rst4 = 1'b0;
        bad = 0;
        for (int e = 0; e < 9; e++) begin
            if (t4 !== (e % 4 == 3)) bad++;
            if (fs4 !== (e == 3)) bad++;
            if (int'(x4) != e / 4) bad++;
            adv(1);
        end
        chk("restart_after_rst", 32'(bad), 32'd0);
        rst4 = 1'b1;

        // DIV=2 line period and h_sync width
        @(negedge clk);
        rst2 = 1'b0;
        f0 = -1; f1 = -1; hclk = 0;
        for (int e = 0; e < 3300; e++) begin
            if (t2 && x2 == 10'd0) begin
                if (f0 < 0) f0 = e;
                else if (f1 < 0) f1 = e;
            end
            if (f0 >= 0 && f1 < 0 && !hs2) hclk++;
            adv(1);
        end
        chk("div2_line_period", 32'(f1 - f0), 32'd1600);
        chk("div2_hsync_clks", 32'(hclk), 32'd192);
        rst2 = 1'b1;

        // small-frame instance: frame period, v_sync, active, wrap
        @(negedge clk);
        rsts = 1'b0;
        f0 = -1; f1 = -1; vclk = 0; vx = -1; vy = -1; acnt = 0;
        corner = 1'b0; cok = 1'b0;
        for (int e = 0; e < 1200; e++) begin
            if (fss) begin
                if (f0 < 0) f0 = e;
                else if (f1 < 0) f1 = e;
            end
            if (f0 >= 0 && f1 < 0) begin
                if (!vss) begin
                    vclk++;
                    if (vx < 0) begin
                        vx = int'(xs);
                        vy = int'(ys);
                    end
                end
                if (ts && as_) acnt++;
            end
            if (ts) begin
                if (corner) cok = (xs == 10'd0) && (ys == 10'd0) && fss;
                corner = (xs == 10'd14) && (ys == 10'd11);
            end
            adv(1);
        end
        chk("frame_first_fs", 32'(f0), 32'd2);
        chk("frame_period", 32'(f1 - f0), 32'd540);
        chk("frame_vsync_clks", 32'(vclk), 32'd90);
        chk("frame_vsync_start", {16'(vx), 16'(vy)}, {16'd0, 16'd8});
        chk("frame_active_ticks", 32'(acnt), 32'd48);
        chk("wrap_corner", 32'(cok), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset, with ports named clk and rst.
REQ-002 The module SHALL have parameter DIV, default 4, meaning clk cycles per pixel; legal values are 2..16.
REQ-003 The module SHALL have parameters H_ACTIVE=640, H_FP=16, H_SYNC=96, H_BP=48, giving pixels per line segment; the line total is 800.
REQ-004 The module SHALL have parameters V_ACTIVE=480, V_FP=10, V_SYNC=2, V_BP=33, giving lines per frame segment; the frame total is 525.
REQ-005 The module SHALL have port clk, input, 1 bit: system clock, 100 MHz nominal.
REQ-006 The module SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-007 The module SHALL have port pix_tick, output, 1 bit: one-clk strobe per pixel period.
REQ-008 The module SHALL have port h_sync, output, 1 bit: horizontal sync, active low.
REQ-009 The module SHALL have port v_sync, output, 1 bit: vertical sync, active low.
REQ-010 The module SHALL have port active, output, 1 bit: high while the current pixel is in the visible area.
REQ-011 The module SHALL have port x, output, 10 bits: current horizontal pixel count, 0..799.
REQ-012 The module SHALL have port y, output, 10 bits: current line count, 0..524.
REQ-013 The module SHALL have port frame_start, output, 1 bit: one-clk strobe on the first pixel of each frame.

Function
REQ-014 The divider register div SHALL count 0..DIV-1 on every clk, then wrap to 0.
REQ-015 pix_tick SHALL be 1 exactly when div==DIV-1, giving one clk high in every DIV clks.
REQ-016 The h counter SHALL advance only on a clk edge where pix_tick==1.
  - h wraps 799->0.
  - On that wrap, the v counter advances; v wraps 524->0.
REQ-017 x SHALL equal the h counter and y SHALL equal the v counter; both are held constant for DIV clks per pixel.
REQ-018 active SHALL be 1 iff x<640 and y<480.
REQ-019 h_sync SHALL be 0 iff 656<=x<752; otherwise 1.
REQ-020 v_sync SHALL be 0 iff 490<=y<492; otherwise 1.
REQ-021 The decodes in REQ-018 to REQ-020 SHALL be registered, so they change on the same clk edge as x and y and never lag them.
REQ-022 frame_start SHALL be 1 iff pix_tick==1 and x==0 and y==0; it is one clk wide, once per frame.
REQ-023 All boundaries SHALL be computed from the parameters, not from literals. Required widths:
  - h and v counters: 10 bits.
  - div: 4 bits.
REQ-024 Wrap conditions SHALL use equality with total-1; the counters SHALL never hold a value at or beyond the total.
REQ-025 Downstream stages SHALL sample x, y and active in the clk cycle where pix_tick==1.

Reset
REQ-026 While rst==1, the following SHALL hold: div=0, h=0, v=0, x=0, y=0, active=1, h_sync=1, v_sync=1, pix_tick=0, frame_start=0.
REQ-027 Reset SHALL take effect immediately at any point in a line or frame, with no completion of the current pixel.
REQ-028 After rst falls, the first pix_tick and frame_start SHALL occur on the DIV-th clk, with x=0 and y=0.

Verification
REQ-029 Reset release check: release rst, DIV=4 -> pix_tick and frame_start high on clk 4 only; x becomes 1 after the clk-4 edge; the next pix_tick is on clk 8.
REQ-030 Line timing check: run 1 line -> x goes 0..799 then 0, y increments by 1; active is high for exactly 640 ticks; h_sync is low for exactly 96 ticks (384 clks), starting at x=656.
REQ-031 Frame timing check: run 1 full frame -> frame_start period is exactly 1,680,000 clks; v_sync is low for 6,400 clks, starting at y=490, x=0; active ticks per frame total 307,200.
REQ-032 Wrap corner check: at x=799, y=524, pix_tick -> next values x=0, y=0; frame_start asserts on the following tick at (0,0).
REQ-033 Mid-operation reset check: assert rst at x=700, y=300, div=2 -> all outputs match REQ-026 in the same cycle, with no sync pulse or tick glitch; restart obeys REQ-028.
REQ-034 Parameter sweep check: DIV=2 -> line period is 1,600 clks and h_sync is low for 192 clks.
